// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch front end for the opcode decoder. Holds the fetch PC and issues word
//   reads to instruction memory (req/ready request, in-order rvalid response).
//   Returned words are buffered in a small FIFO and presented to decode as
//   {instr, instr_pc} with a valid/ready handshake. A redirect flushes the FIFO,
//   reloads the PC and marks every outstanding response as stale.
//
//   Optional feature macro: IFU_PERF_CNT_EN adds perf_fetched / perf_stall.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/addr/ready           request channel (word aligned address)
//   imem_rvalid/rdata             response channel, one per accepted request
//   instr_valid/instr/instr_pc    FIFO head toward decode
//   instr_ready                   decode consumes the head
//   redirect_valid/redirect_pc    restart fetch at redirect_pc (low bits dropped)
//   perf_fetched/perf_stall       [IFU_PERF_CNT_EN] saturating event counters
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count, inflight, discard;
  logic [PW-1:0] wr_ptr, rd_ptr;
  fetch_ent_t    fifo_q [FIFO_DEPTH];

  logic          credit_ok, hs, pop, rsp_drop, rsp_take, rsp_any, push, push_head;
  logic [CW-1:0] cnt_nxt, disc_redir;
  logic [PW-1:0] rd_nxt;
  logic [31:0]   rsp_pc;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts FIFO slots already filled plus slots promised to requests in
  // flight, so a returning response always has room.
  assign credit_ok   = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req    = (state == RUN) & credit_ok & ~redirect_valid;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);

  assign hs       = imem_req & imem_ready;
  assign pop      = instr_valid & instr_ready;
  assign rsp_drop = imem_rvalid & (discard != '0);
  assign rsp_take = imem_rvalid & (discard == '0) & (inflight != '0);
  assign rsp_any  = rsp_drop | rsp_take;
  assign push     = rsp_take & ~redirect_valid;

  // Live requests are consecutive words ending just below fetch_pc, so the
  // oldest one (the one answering now) sits inflight words back.
  assign rsp_pc   = fetch_pc - 32'({inflight, 2'b00});

  assign cnt_nxt    = count + CW'(push) - CW'(pop);
  assign rd_nxt     = pop ? inc_ptr(rd_ptr) : rd_ptr;
  // The pushed word becomes the head when nothing else remains after the pop.
  assign push_head  = push & ((count - CW'(pop)) == '0);
  // The response arriving with a redirect is counted as stale and dropped now.
  assign disc_redir = discard + inflight - CW'(rsp_any);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{instr: imem_rdata, pc: rsp_pc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h3;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= '0;
      discard  <= disc_redir;
      state    <= (disc_redir != '0) ? DRAIN : RUN;
    end else begin
      if (hs) fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CW'(hs) - CW'(rsp_take);
      discard  <= discard - CW'(rsp_drop);
      count    <= cnt_nxt;
      rd_ptr   <= rd_nxt;
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      case (state)
        BOOT:    state <= RUN;
        DRAIN:   if ((discard - CW'(rsp_drop)) == '0) state <= RUN;
        default: state <= RUN;
      endcase
      // Head register holds its last value while the FIFO is empty.
      if (cnt_nxt != '0) begin
        if (push_head) begin
          instr    <= imem_rdata;
          instr_pc <= rsp_pc;
        end else begin
          instr    <= fifo_q[rd_nxt].instr;
          instr_pc <= fifo_q[rd_nxt].pc;
        end
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else if (state != BOOT) begin
      if (pop && !(&perf_fetched)) perf_fetched <= perf_fetched + 32'd1;
      if (instr_ready && !instr_valid && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
